// File: rtl/led_pwm_driver.sv
// led_pwm_driver: off/on/blink/breathe PWM drive for the user LED; commands apply at PWM period boundaries.
// Define LED_PWM_GAMMA_EN to add a square-law gamma stage after scaling.
module led_pwm_driver #(
  parameter int BLINK_DIV = 6000000,
  parameter int STEP_DIV = 23437
) (
  input  logic       clk_12mhz,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_level,
  output logic [1:0] mode,
  output logic       period_start,
  output logic       led
);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [1:0] M_ON = 2'd1, M_BLINK = 2'd2, M_BREATHE = 2'd3;
  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;
  state_t state, state_next;
  logic armed, phase, dir, on_gate, accept, apply, blink_wrap, step_wrap;
  logic [7:0] pwm_cnt, level, pend_level, ramp, ramp_next, scaled;
  logic [1:0] pend_mode;
  logic [BW-1:0] blink_cnt;
  logic [SW-1:0] step_cnt;
  logic [15:0] prod;
  logic [8:0] duty_eff;
`ifdef LED_PWM_GAMMA_EN
  logic [15:0] sq;
`endif
  always_ff @(posedge clk_12mhz or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  // DONE holds cmd_ready low for the first cycle of the new period
  always_comb begin
    cmd_ready = state == IDLE;
    accept = cmd_valid && cmd_ready;
    apply = state == PEND && pwm_cnt == 8'hff;
    state_next = accept ? PEND : apply ? DONE : state == DONE ? IDLE : state;
  end
  always_comb begin
    blink_wrap = blink_cnt == BLINK_LAST;
    step_wrap = step_cnt == STEP_LAST;
    ramp_next = dir ? ramp - 8'd1 : ramp + 8'd1;
    prod = {8'd0, ramp} * ({8'd0, level} + 16'd1);
    scaled = mode == M_BREATHE ? prod[15:8] : level;
    on_gate = mode == M_ON || mode == M_BREATHE || (mode == M_BLINK && phase);
`ifdef LED_PWM_GAMMA_EN
    sq = {8'd0, scaled} * {8'd0, scaled};
    duty_eff = &scaled ? 9'd256 : {1'b0, sq[15:8]};
`else
    duty_eff = &scaled ? 9'd256 : {1'b0, scaled};
`endif
    period_start = armed && pwm_cnt == 8'd0;
  end
  // armed holds pwm_cnt at 0 for one cycle after reset so the first period starts right after release
  always_ff @(posedge clk_12mhz or posedge rst)
    if (rst) begin
      armed <= 1'b0;
      pwm_cnt <= 8'd0;
      led <= 1'b0;
      mode <= 2'd0;
      level <= 8'd0;
      pend_mode <= 2'd0;
      pend_level <= 8'd0;
      blink_cnt <= '0;
      phase <= 1'b1;
      step_cnt <= '0;
      ramp <= 8'd0;
      dir <= 1'b0;
    end else begin
      armed <= 1'b1;
      pwm_cnt <= pwm_cnt + {7'd0, armed};
      led <= on_gate && {1'b0, pwm_cnt} < duty_eff;
      if (accept) begin
        pend_mode <= cmd_mode;
        pend_level <= cmd_level;
      end
      if (apply) begin
        mode <= pend_mode;
        level <= pend_level;
        blink_cnt <= '0;
        phase <= 1'b1;
        step_cnt <= '0;
        ramp <= 8'd0;
        dir <= 1'b0;
      end else begin
        blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
        step_cnt <= step_wrap ? '0 : step_cnt + SW'(1);
        if (blink_wrap) phase <= ~phase;
        if (step_wrap) begin
          ramp <= ramp_next;
          if (ramp_next == 8'hff || ramp_next == 8'h00) dir <= ~dir;
        end
      end
    end
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: randomized command stimulus checked against a time-based model of the LED waveform.
module tb_led_pwm_driver;
  localparam int BD = 1000, SD = 4;
  logic clk_12mhz = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic cmd_ready, period_start, led;
  logic [1:0] cmd_mode = 2'd0, mode;
  logic [7:0] cmd_level = 8'd0;
  int errors = 0, checks = 0;
  led_pwm_driver #(.BLINK_DIV(BD), .STEP_DIV(SD)) dut (
    .clk_12mhz(clk_12mhz), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_level(cmd_level), .mode(mode),
    .period_start(period_start), .led(led)
  );
  always #5 clk_12mhz = ~clk_12mhz;
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic int duty_of(int s);
    if (s == 255) return 256;
`ifdef LED_PWM_GAMMA_EN
    return (s * s) >> 8;
`else
    return s;
`endif
  endfunction
  // t counts cycles from the first cycle of the period in which a command took effect
  function automatic int ramp_at(int t);
    int m;
    m = (t / SD) % 510;
    return m <= 255 ? m : 510 - m;
  endfunction
  function automatic bit model_led(int m, int l, int t);
    int s;
    if (m == 0 || (m == 2 && (t / BD) % 2 == 1)) return 1'b0;
    s = m == 3 ? (ramp_at(t) * (l + 1)) >> 8 : l;
    return (t % 256) < duty_of(s);
  endfunction
  task automatic step();
    @(posedge clk_12mhz);
    #1;
  endtask
  task automatic sync_pwm(input int k);
    int n;
    n = 0;
    step();
    while (!period_start && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL sync_period_start: period_start=%0b required 1 within 300 cycles", period_start);
    end
    repeat (k) step();
  endtask
  task automatic send(input logic [1:0] m, input logic [7:0] l, input int k, output int to_t0);
    sync_pwm(k);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_send: cmd_ready=%0b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_mode = m;
    cmd_level = l;
    step();
    cmd_valid = 1'b0;
    cmd_mode = 2'($urandom);
    cmd_level = 8'($urandom);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_accept: cmd_ready=%0b required 0", cmd_ready);
    end
    to_t0 = k == 255 ? 256 : 255 - k;
  endtask
  task automatic measure(input int m, input int l, input int t0, input int len, output int obs, output int exp);
    obs = 0;
    exp = 0;
    for (int i = 0; i < len; i++) begin
      step();
      obs += int'(led);
      exp += int'(model_led(m, l, t0 + i));
    end
  endtask
  task automatic test_reset();
    repeat (3) step();
    checks += 4;
    if (led !== 1'b0) begin errors++; $display("FAIL reset_led: led=%0b required 0", led); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: cmd_ready=%0b required 1", cmd_ready); end
    if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: mode=%0d required 0", mode); end
    if (period_start !== 1'b0) begin errors++; $display("FAIL reset_period_start: period_start=%0b required 0", period_start); end
    rst = 1'b0;
    step();
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL first_period_start: period_start=%0b required 1", period_start); end
  endtask
  task automatic test_idle();
    int cnt, hi, bad;
    hi = 0;
    bad = 0;
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      do begin
        step();
        cnt++;
        hi += int'(led);
        bad += int'(cmd_ready !== 1'b1 || mode !== 2'd0);
      end while (!period_start && cnt < 300);
      checks++;
      if (cnt != 256) begin errors++; $display("FAIL idle_period: interval=%0d required 256", cnt); end
    end
    checks += 2;
    if (hi != 0) begin errors++; $display("FAIL idle_led: high_cycles=%0d required 0", hi); end
    if (bad != 0) begin errors++; $display("FAIL idle_status: bad_cycles=%0d required 0", bad); end
  endtask
  task automatic test_on();
    int n, k, obs, exp;
    logic [7:0] lv [4];
    lv = '{8'd64, 8'd255, 8'($urandom_range(1, 254)), 8'($urandom)};
    for (int j = 0; j < 4; j++) begin
      k = j == 0 ? 10 : $urandom_range(0, 254);
      send(2'd1, lv[j], k, n);
      repeat (n - 1) step();
      if (j == 0) begin
        checks++;
        if (mode !== 2'd0) begin errors++; $display("FAIL on_latency_pre: mode=%0d required 0", mode); end
      end
      step();
      checks += 2;
      if (mode !== 2'd1) begin errors++; $display("FAIL on_mode: mode=%0d required 1", mode); end
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL on_ready_t0: cmd_ready=%0b required 0", cmd_ready); end
      measure(1, int'(lv[j]), 0, 1, obs, exp);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL on_ready_t1: cmd_ready=%0b required 1", cmd_ready); end
      measure(1, int'(lv[j]), 1, 256, obs, exp);
      checks++;
      if (obs != exp) begin errors++; $display("FAIL on_duty level=%0d: high=%0d required %0d", lv[j], obs, exp); end
    end
  endtask
  task automatic test_blink();
    int n, obs, exp;
    logic [7:0] l;
    send(2'd1, 8'd128, $urandom_range(0, 255), n);
    repeat (n) step();
    measure(1, 128, 0, 256, obs, exp);
    checks++;
    if (obs != exp) begin errors++; $display("FAIL blink_pre_on: high=%0d required %0d", obs, exp); end
    send(2'd2, 8'd255, $urandom_range(0, 255), n);
    repeat (n) step();
    checks++;
    if (mode !== 2'd2) begin errors++; $display("FAIL blink_mode: mode=%0d required 2", mode); end
    for (int w = 0; w < 4; w++) begin
      measure(2, 255, w * BD, BD, obs, exp);
      checks++;
      if (obs != exp) begin errors++; $display("FAIL blink_window %0d: high=%0d required %0d", w, obs, exp); end
    end
    l = 8'($urandom_range(1, 254));
    send(2'd2, l, $urandom_range(0, 255), n);
    repeat (n) step();
    for (int w = 0; w < 2; w++) begin
      measure(2, int'(l), w * BD, BD, obs, exp);
      checks++;
      if (obs != exp) begin errors++; $display("FAIL blink_level %0d window %0d: high=%0d required %0d", l, w, obs, exp); end
    end
  endtask
  task automatic test_breathe();
    int n, obs, exp;
    logic [7:0] l;
    send(2'd3, 8'd255, $urandom_range(0, 255), n);
    repeat (n) step();
    for (int p = 0; p < 8; p++) begin
      measure(3, 255, p * 256, 256, obs, exp);
      checks++;
      if (obs != exp) begin errors++; $display("FAIL breathe_full period %0d: high=%0d required %0d", p, obs, exp); end
    end
    l = 8'($urandom);
    send(2'd3, l, $urandom_range(0, 255), n);
    repeat (n) step();
    for (int p = 0; p < 4; p++) begin
      measure(3, int'(l), p * 256, 256, obs, exp);
      checks++;
      if (obs != exp) begin errors++; $display("FAIL breathe_level %0d period %0d: high=%0d required %0d", l, p, obs, exp); end
    end
  endtask
  task automatic test_back_to_back();
    int n, low, obs, exp;
    logic [7:0] l2;
    l2 = 8'($urandom);
    send(2'd1, 8'($urandom), 255, n);
    cmd_valid = 1'b1;
    cmd_mode = 2'd3;
    cmd_level = l2;
    low = 0;
    while (!cmd_ready && low < 400) begin
      low++;
      step();
    end
    checks += 2;
    if (low != 257) begin errors++; $display("FAIL b2b_ready_low: low_cycles=%0d required 257", low); end
    if (mode !== 2'd1) begin errors++; $display("FAIL b2b_first_mode: mode=%0d required 1", mode); end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: cmd_ready=%0b required 0", cmd_ready); end
    repeat (253) step();
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL b2b_second_pre: mode=%0d required 1", mode); end
    step();
    checks++;
    if (mode !== 2'd3) begin errors++; $display("FAIL b2b_second_mode: mode=%0d required 3", mode); end
    measure(3, int'(l2), 0, 256, obs, exp);
    checks++;
    if (obs != exp) begin errors++; $display("FAIL b2b_second_duty: high=%0d required %0d", obs, exp); end
  endtask
  task automatic test_reset_pending();
    int n, hi, bad;
    send(2'd1, 8'd255, $urandom_range(0, 255), n);
    repeat (n + 2) step();
    send(2'd3, 8'($urandom), $urandom_range(0, 250), n);
    repeat ($urandom_range(0, n - 1)) step();
    checks += 2;
    if (mode !== 2'd1) begin errors++; $display("FAIL rstp_pre_mode: mode=%0d required 1", mode); end
    if (led !== 1'b1) begin errors++; $display("FAIL rstp_pre_led: led=%0b required 1", led); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (led !== 1'b0) begin errors++; $display("FAIL rstp_led: led=%0b required 0", led); end
    if (mode !== 2'd0) begin errors++; $display("FAIL rstp_mode: mode=%0d required 0", mode); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstp_ready: cmd_ready=%0b required 1", cmd_ready); end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL rstp_period_start: period_start=%0b required 1", period_start); end
    hi = 0;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      hi += int'(led);
      bad += int'(mode !== 2'd0 || cmd_ready !== 1'b1);
    end
    checks += 2;
    if (hi != 0) begin errors++; $display("FAIL rstp_led_after: high_cycles=%0d required 0", hi); end
    if (bad != 0) begin errors++; $display("FAIL rstp_discard: bad_cycles=%0d required 0", bad); end
  endtask
  initial begin
    test_reset();
    test_idle();
    test_on();
    test_blink();
    test_breathe();
    test_back_to_back();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
